// File: rtl/theft_monitor.sv
// theft_monitor: registered stolen-item detector with a timed alarm, a latched
// lockout after repeated thefts in one alarm episode, and a saturating theft
// counter for the display logic.
module theft_monitor #(
  parameter int                      UPC_W        = 3,
  parameter logic [(1<<UPC_W)-1:0]   STOLEN_MASK  = 8'h35,
  parameter int                      ALARM_CYCLES = 8,
  parameter int                      LOCK_THRESH  = 3,
  parameter int                      CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_valid,
  input  logic [UPC_W-1:0] upc,
  input  logic             marked,
  input  logic             clear,
  output logic             scan_ready,
  output logic             out_valid,
  output logic             stolen,
  output logic             alarm,
  output logic             locked,
  output logic [CNT_W-1:0] theft_count
);

  localparam int TMR_W = $clog2(ALARM_CYCLES + 1);
  localparam int EP_W  = $clog2(LOCK_THRESH + 1);

  localparam logic [TMR_W-1:0] ALARM_LOAD = TMR_W'(ALARM_CYCLES);
  localparam logic [EP_W-1:0]  LOCK_LIM   = EP_W'(LOCK_THRESH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALARM  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [EP_W-1:0]  r_episode, w_episode_nxt, w_episode_inc;
  logic             r_out_valid;
  logic             r_stolen;
  logic [CNT_W-1:0] r_theft_count;
  logic             w_accept;
  logic             w_theft;

  // Scans are refused only while locked out; everything else follows from acceptance.
  assign scan_ready    = (r_state != S_LOCKED);
  assign w_accept      = scan_valid && scan_ready;
  assign w_theft       = w_accept && !marked && STOLEN_MASK[upc];
  assign w_episode_inc = r_episode + 1'b1;

  assign out_valid   = r_out_valid;
  assign stolen      = r_stolen;
  assign alarm       = (r_state != S_IDLE);
  assign locked      = (r_state == S_LOCKED);
  assign theft_count = r_theft_count;

  // Next-state logic: a theft beats both clear and timer expiry while in ALARM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_episode_nxt = r_episode;
    case (r_state)
      S_IDLE: begin
        if (w_theft) begin
          w_state_nxt   = S_ALARM;
          w_timer_nxt   = ALARM_LOAD;
          w_episode_nxt = EP_W'(1);
        end
      end
      S_ALARM: begin
        if (w_theft) begin
          w_timer_nxt   = ALARM_LOAD;
          w_episode_nxt = w_episode_inc;
          if (w_episode_inc == LOCK_LIM) begin
            w_state_nxt = S_LOCKED;
          end
        end else if (clear || (r_timer <= TMR_W'(1))) begin
          w_state_nxt   = S_IDLE;
          w_timer_nxt   = '0;
          w_episode_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_LOCKED: begin
        if (clear) begin
          w_state_nxt   = S_IDLE;
          w_timer_nxt   = '0;
          w_episode_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_timer_nxt   = '0;
        w_episode_nxt = '0;
      end
    endcase
  end

  // State, result and counter registers; reset is synchronous and has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_episode     <= '0;
      r_out_valid   <= 1'b0;
      r_stolen      <= 1'b0;
      r_theft_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_episode   <= w_episode_nxt;
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_stolen <= w_theft;
      end
      if (w_theft && (r_theft_count != '1)) begin
        r_theft_count <= r_theft_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_theft_monitor.sv
// Self-checking bench for theft_monitor: directed scenarios plus random traffic,
// compared every cycle against a behavioural model, on a default instance and on
// a second instance with short alarm, low threshold, other mask and 2-bit count.
module tb_theft_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_valid;
  logic [2:0] upc;
  logic       marked;
  logic       clear;

  logic       sr0, ov0, st0, al0, lk0;
  logic [7:0] cnt0;
  logic       sr1, ov1, st1, al1, lk1;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  theft_monitor u_dut0 (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .upc(upc), .marked(marked),
    .clear(clear), .scan_ready(sr0), .out_valid(ov0), .stolen(st0), .alarm(al0),
    .locked(lk0), .theft_count(cnt0)
  );

  theft_monitor #(
    .UPC_W(3), .STOLEN_MASK(8'hC3), .ALARM_CYCLES(3), .LOCK_THRESH(2), .CNT_W(2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .upc(upc), .marked(marked),
    .clear(clear), .scan_ready(sr1), .out_valid(ov1), .stolen(st1), .alarm(al1),
    .locked(lk1), .theft_count(cnt1)
  );

  // Model parameters per instance.
  int         p_alarm[2]  = '{8, 3};
  int         p_thresh[2] = '{3, 2};
  int         p_cmax[2]   = '{255, 3};
  logic [7:0] p_mask[2]   = '{8'h35, 8'hC3};

  // Model state: remaining alarm cycles, thefts in this episode, lockout, count, outputs.
  int m_left[2], m_ep[2], m_cnt[2];
  bit m_lock[2], m_ov[2], m_st[2];

  int n_checks = 0;
  int n_pass   = 0;
  int pulses0  = 0;
  int hi0      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One edge of the behavioural model, applied to the inputs held across that edge.
  task automatic model_step();
    bit acc, th;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_left[k] = 0; m_ep[k] = 0; m_cnt[k] = 0;
        m_lock[k] = 0; m_ov[k] = 0; m_st[k] = 0;
      end else begin
        acc = scan_valid && !m_lock[k];
        th  = acc && !marked && p_mask[k][upc];
        m_ov[k] = acc;
        if (acc) m_st[k] = th;
        if (th && m_cnt[k] < p_cmax[k]) m_cnt[k]++;
        if (m_lock[k]) begin
          if (clear) begin m_lock[k] = 0; m_left[k] = 0; m_ep[k] = 0; end
        end else if (th) begin
          m_ep[k]++;
          m_left[k] = p_alarm[k];
          if (m_ep[k] == p_thresh[k]) m_lock[k] = 1;
        end else if (m_left[k] > 0) begin
          if (clear) begin
            m_left[k] = 0; m_ep[k] = 0;
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) m_ep[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare();
    check("ov0",  32'(ov0),  32'(m_ov[0]));
    check("st0",  32'(st0),  32'(m_st[0]));
    check("al0",  32'(al0),  32'(m_lock[0] || m_left[0] > 0));
    check("lk0",  32'(lk0),  32'(m_lock[0]));
    check("sr0",  32'(sr0),  32'(!m_lock[0]));
    check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
    check("ov1",  32'(ov1),  32'(m_ov[1]));
    check("st1",  32'(st1),  32'(m_st[1]));
    check("al1",  32'(al1),  32'(m_lock[1] || m_left[1] > 0));
    check("lk1",  32'(lk1),  32'(m_lock[1]));
    check("sr1",  32'(sr1),  32'(!m_lock[1]));
    check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    if (ov0 === 1'b1) pulses0++;
    if (al0 === 1'b1) hi0++;
  endtask

  // Drive inputs away from the edge, let the edge happen, then compare 1 ns later.
  task automatic tick(input logic rst, input logic v, input logic [2:0] u,
                      input logic m, input logic c);
    reset = rst; scan_valid = v; upc = u; marked = m; clear = c;
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic theft();
    tick(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] combo;
    reset = 1'b1; scan_valid = 1'b0; upc = '0; marked = 1'b0; clear = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_sr0",  32'(sr0),  32'd1);

    // Exhaustive classification.
    pulses0 = 0;
    for (int i = 0; i < 16; i++) begin
      combo = 4'(i);
      tick(1'b0, 1'b1, combo[3:1], combo[0], 1'b0);
      idle(12);
    end
    check("exh_count",  32'(cnt0), 32'd4);
    check("exh_pulses", 32'(pulses0), 32'd16);

    // Single theft: alarm high for exactly 8 cycles.
    do_reset();
    hi0 = 0;
    theft();
    idle(12);
    check("alarm_len", 32'(hi0), 32'd8);

    // Reload at N+7: alarm continuous for 15 cycles.
    do_reset();
    hi0 = 0;
    theft();
    idle(6);
    theft();
    idle(14);
    check("reload_len", 32'(hi0), 32'd15);

    // Lockout after three thefts two cycles apart.
    do_reset();
    theft(); idle(1); theft(); idle(1); theft();
    check("lock_lk", 32'(lk0), 32'd1);
    check("lock_sr", 32'(sr0), 32'd0);
    theft();
    check("lock_noov",  32'(ov0),  32'd0);
    check("lock_count", 32'(cnt0), 32'd3);
    tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("clr_al", 32'(al0), 32'd0);
    check("clr_lk", 32'(lk0), 32'd0);
    check("clr_sr", 32'(sr0), 32'd1);

    // Saturation on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      theft();
      check($sformatf("sat_%0d", i), 32'(cnt1), (i < 3) ? 32'(i + 1) : 32'd3);
      idle(9);
    end

    // Theft together with clear in ALARM reloads the timer.
    do_reset();
    theft(); idle(2);
    tick(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    idle(7);
    check("tc_alarm_hold", 32'(al0), 32'd1);
    idle(1);
    check("tc_alarm_end", 32'(al0), 32'd0);

    // Reset mid-alarm.
    do_reset();
    theft(); idle(1); theft();
    check("pre_rst_cnt", 32'(cnt0), 32'd2);
    check("pre_rst_al",  32'(al0),  32'd1);
    do_reset();
    check("mid_rst_cnt", 32'(cnt0), 32'd0);
    check("mid_rst_al",  32'(al0),  32'd0);
    check("mid_rst_st",  32'(st0),  32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/theft_monitor.md
# theft_monitor

Registered, parametrised successor to the combinational stolen-item detector in the checkout lab. Each accepted scan presents an item code and a "marked" flag. The block classifies the scan against a per-code stolen mask and raises a timed alarm on stolen items. It escalates to a latched lockout after repeated thefts within one alarm episode and keeps a saturating theft count for the 7-segment/LEDR display logic.

## Interface
- UPC_W, 3: item code width; code order is {U, P, C} (U is the MSB).
- STOLEN_MASK, 8'h35: 2**UPC_W bits; bit k=1 means code k is stolen when unmarked. The default reproduces the lab rule: codes 0, 2, 4 and 5.
- ALARM_CYCLES, 8: cycles the alarm stays high after the last stolen scan; must be ≥ 1.
- LOCK_THRESH, 3: stolen scans within one alarm episode that force lockout; must be ≥ 2.
- CNT_W, 8: width of theft_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- scan_valid  input  1  a scan is presented this cycle.
- upc  input  UPC_W  item code; sampled only when a scan is accepted.
- marked  input  1  item carries the M mark; sampled with upc.
- clear  input  1  operator clear; synchronous, level-sampled.
- scan_ready  output  1  block accepts scans; combinational, 0 only in LOCKED.
- out_valid  output  1  one-cycle pulse; the stolen output is valid.
- stolen  output  1  classification of the most recent accepted scan; holds between scans.
- alarm  output  1  alarm indicator.
- locked  output  1  lockout indicator.
- theft_count  output  CNT_W  total stolen scans since reset; saturating.

## Operation
- A scan is accepted when scan_valid && scan_ready.
- is_theft = accepted && !marked && STOLEN_MASK[upc].
- States and transitions:
  - IDLE: alarm=0, locked=0. An accepted theft moves to ALARM, loads the timer with ALARM_CYCLES and sets the episode count to 1.
  - ALARM: alarm=1.
    - Theft this cycle: reload the timer and increment the episode count. If the new count equals LOCK_THRESH, go to LOCKED.
    - Otherwise, if clear is high, go to IDLE.
    - Otherwise the timer decrements; the transition to IDLE happens on the edge where the timer goes 1→0.
  - LOCKED: alarm=1, locked=1, scan_ready=0; scans are ignored and produce no out_valid. Only clear (or reset) returns to IDLE; clear in LOCKED wins unconditionally.
- Simultaneous events in ALARM:
  - A theft together with clear: the theft wins; stay in ALARM (or go to LOCKED), with the timer reloaded.
  - A theft on the same edge the timer would expire: the theft wins; the timer is reloaded.
- The episode count resets to 0 on entry to IDLE. A non-theft scan does not affect the timer or the episode count.
- theft_count increments on every accepted theft and saturates at 2**CNT_W−1 with no wrap.
- clear does not affect theft_count; only reset zeroes it.
- Timer width is $clog2(ALARM_CYCLES+1). Episode counter width is $clog2(LOCK_THRESH+1).

## Timing
- Reset values:
  - state = IDLE.
  - out_valid, stolen, alarm and locked = 0.
  - theft_count = 0.
  - scan_ready = 1 once reset is released. Scans presented while reset is high are dropped.
- Latency: a scan accepted on edge N gives out_valid=1 and a valid stolen value during the cycle after edge N (one-cycle latency).
  - alarm, locked and theft_count reflect that scan in the same cycle as its out_valid.
- Back-to-back scans, one per cycle, are supported at full rate.
- Alarm duration: a single theft accepted at edge N gives alarm=1 after edges N through N+ALARM_CYCLES−1, and alarm=0 after edge N+ALARM_CYCLES. That is exactly ALARM_CYCLES cycles high.
- clear is sampled at an edge; alarm falls in the cycle after that edge.
- Reset asserted mid-ALARM or mid-LOCKED returns every output to its reset value at the next edge.

## Test plan
- Exhaustive classification: all 16 {upc, marked} combos with default parameters, one per cycle, with a 12-cycle idle gap between combos. Required: stolen=1 only for upc ∈ {0, 2, 4, 5} with marked=0. Final theft_count=4, and out_valid pulses exactly 16 times.
- Alarm timing: one theft (upc=0, marked=0) at edge N. Required: alarm high for exactly 8 cycles, starting in the out_valid cycle; locked stays 0.
- Reload versus expiry: a theft at edge N, then a second theft at edge N+7. Required: alarm stays high continuously through the cycle after edge N+14 and falls after edge N+15.
- Lockout: three thefts 2 cycles apart. Required:
  - locked=1 and scan_ready=0 after the third theft is accepted.
  - A further theft scan produces no out_valid and no count change.
  - clear returns the block to alarm=0, locked=0, scan_ready=1 on the next cycle.
- Saturation and priority: CNT_W=2, 5 thefts. Required: theft_count = 1, 2, 3, 3, 3. A theft and clear together in ALARM keeps alarm=1 and reloads the timer.
- Reset mid-alarm: reset for 1 cycle during ALARM with theft_count=2. Required: every output takes its reset value on the next cycle, including theft_count=0.
